id_ex_stage: RTL

- ID/EX pipeline register plus operand-forwarding and ALU-control logic for the pipelined MIPS core.
- Captures decoded operands and control from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operands and 3-bit aluop for the cycle the instruction sits in EX.
- Detects load-use hazards and bubbles EX while signalling IF/ID to hold.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/ex_fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: ALU opcodes, R-type funct codes,
// ALU class codes and default datapath widths.
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_SUB   = 2'b01;
    localparam logic [1:0] CLS_FUNCT = 2'b10;
    localparam logic [1:0] CLS_RSVD  = 2'b11;

    // Returns {illegal, aluop}; the reserved class quietly behaves as add.
    function automatic logic [3:0] alu_decode(input logic [1:0] cls, input logic [5:0] funct);
        logic [3:0] r;
        r = {1'b0, ALU_ADD};
        if (cls == CLS_SUB) begin
            r = {1'b0, ALU_SUB};
        end else if (cls == CLS_FUNCT) begin
            case (funct)
                FN_ADD:  r = {1'b0, ALU_ADD};
                FN_SUB:  r = {1'b0, ALU_SUB};
                FN_AND:  r = {1'b0, ALU_AND};
                FN_OR:   r = {1'b0, ALU_OR};
                FN_SLT:  r = {1'b0, ALU_SLT};
                default: r = {1'b1, ALU_ADD};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Forward-select for one EX operand: EX/MEM beats MEM/WB beats the value
// captured from the register file. Register 0 is never forwarded.
module ex_fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] data
);

    logic hit_exmem, hit_memwb;

    assign hit_exmem = exmem_regwrite & (exmem_rd != '0) & (exmem_rd == idx);
    assign hit_memwb = memwb_regwrite & (memwb_rd != '0) & (memwb_rd == idx);

    assign data = hit_exmem ? exmem_result :
                  hit_memwb ? memwb_result : reg_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered ALU decode, load-use bubble
// insertion and combinational operand forwarding into EX.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_alu_class,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    input  logic          flush,
    input  logic          hold,
    output logic          stall_out,
    output logic          ex_valid,
    output logic [DW-1:0] ex_in1,
    output logic [DW-1:0] ex_in2,
    output logic [2:0]    ex_aluop,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wreg,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          ex_illegal
);

    logic          valid_q, valid_d;
    logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
    logic [2:0]    aluop_q, aluop_d;
    logic          illegal_q, illegal_d, alusrc_q, alusrc_d;
    logic          regwrite_q, regwrite_d, memread_q, memread_d;
    logic          memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;

    logic          load_use;
    logic [3:0]    dec;
    logic [DW-1:0] fwd_rs, fwd_rt;

    assign load_use = valid_q & memread_q & (wreg_q != '0) & id_valid &
                      ((wreg_q == id_rs) | (wreg_q == id_rt));
    assign stall_out = (hold | load_use) & ~flush;
    assign dec       = alu_decode(id_alu_class, id_funct);

    always_comb begin
        valid_d    = valid_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wreg_d     = wreg_q;
        aluop_d    = aluop_q;
        illegal_d  = illegal_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        // A bubble looks exactly like the reset state.
        if (flush || (!hold && load_use)) begin
            valid_d    = 1'b0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            wreg_d     = '0;
            aluop_d    = ALU_ADD;
            illegal_d  = 1'b0;
            alusrc_d   = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
        end else if (!hold) begin
            valid_d    = id_valid;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            rs_d       = id_rs;
            rt_d       = id_rt;
            wreg_d     = id_regdst ? id_rd : id_rt;
            aluop_d    = dec[2:0];
            illegal_d  = dec[3] & id_valid;
            alusrc_d   = id_alusrc;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
            memtoreg_d = id_memtoreg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            aluop_q    <= ALU_ADD;
            illegal_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wreg_q     <= wreg_d;
            aluop_q    <= aluop_d;
            illegal_q  <= illegal_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    ex_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx(rs_q), .reg_data(rs_data_q),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .data(fwd_rs)
    );

    ex_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx(rt_q), .reg_data(rt_data_q),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .data(fwd_rt)
    );

    assign ex_valid      = valid_q;
    assign ex_in1        = fwd_rs;
    assign ex_in2        = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_aluop      = aluop_q;
    assign ex_wreg       = wreg_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_memtoreg   = memtoreg_q;
    assign ex_illegal    = illegal_q;

endmodule
